// File: rtl/stream_mux_nch.sv
// Registered N-channel stream multiplexer with packet locking.
// Grant comes from an external select (MODE=0) or round-robin arbitration (MODE=1).
module stream_mux_nch #(
   parameter int WORD_SIZE = 8,
   parameter int NUM_CH    = 4,
   parameter int MODE      = 0,
   localparam int SEL_W    = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [SEL_W-1:0]            sel,
   input  logic [NUM_CH*WORD_SIZE-1:0] in_data,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH-1:0]           in_last,
   output logic [NUM_CH-1:0]           in_ready,
   output logic [WORD_SIZE-1:0]        out_data,
   output logic                        out_valid,
   output logic                        out_last,
   output logic [SEL_W-1:0]            out_ch,
   input  logic                        out_ready,
   output logic                        sel_err
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(NUM_CH);

   state_t                 state_q, state_d;
   logic [SEL_W-1:0]       grant_q, grant_d;
   logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [WORD_SIZE-1:0]   out_data_q, out_data_d;
   logic                   out_last_q, out_last_d;
   logic [SEL_W-1:0]       out_ch_q, out_ch_d;
   logic                   out_valid_q, out_valid_d;

   logic [WORD_SIZE-1:0]   ch_data [NUM_CH];
   logic [NUM_CH-1:0]      ready_raw;
   logic                   sel_err_raw;
   logic                   found;
   logic [SEL_W-1:0]       cand;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign ch_data[k] = in_data[k*WORD_SIZE +: WORD_SIZE];
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ready_raw   = '0;
      sel_err_raw = 1'b0;
      found       = 1'b0;
      cand        = '0;

      case (state_q)
         IDLE: begin
            if (MODE == 0) begin
               if ({1'b0, sel} >= CH_LIM) begin
                  sel_err_raw = 1'b1;
               end else if (in_valid[sel]) begin
                  grant_d = sel;
                  state_d = LOCKED;
               end
            end else begin
               // Search starts just past the last winner so every channel gets a turn.
               for (int i = 1; i <= NUM_CH; i++) begin
                  cand = SEL_W'((int'(rr_ptr_q) + i) % NUM_CH);
                  if (!found && in_valid[cand]) begin
                     found    = 1'b1;
                     grant_d  = cand;
                     rr_ptr_d = cand;
                     state_d  = LOCKED;
                  end
               end
            end
         end
         LOCKED: begin
            ready_raw[grant_q] = !out_valid_q || out_ready;
         end
         default: state_d = IDLE;
      endcase

      if (state_q == LOCKED && in_valid[grant_q] && ready_raw[grant_q]) begin
         out_data_d  = ch_data[grant_q];
         out_last_d  = in_last[grant_q];
         out_ch_d    = grant_q;
         out_valid_d = 1'b1;
         if (in_last[grant_q]) state_d = IDLE;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Handshake outputs are held quiet while reset is asserted.
   assign in_ready  = rst_n ? ready_raw : '0;
   assign sel_err   = rst_n & sel_err_raw;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= SEL_W'(NUM_CH - 1);
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_stream_mux_nch.sv
// Directed bench for stream_mux_nch: select mode (4 and 3 channels) and round-robin mode.
module tb_stream_mux_nch;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int errs   = 0;
   int checks = 0;

   // Instance A: MODE=0, NUM_CH=4
   logic [1:0]  sel_a;
   logic [31:0] in_data_a;
   logic [3:0]  in_valid_a, in_last_a, in_ready_a;
   logic [7:0]  out_data_a;
   logic        out_valid_a, out_last_a, out_ready_a, sel_err_a;
   logic [1:0]  out_ch_a;

   // Instance B: MODE=1, NUM_CH=4
   logic [1:0]  sel_b;
   logic [31:0] in_data_b;
   logic [3:0]  in_valid_b, in_last_b, in_ready_b;
   logic [7:0]  out_data_b;
   logic        out_valid_b, out_last_b, out_ready_b, sel_err_b;
   logic [1:0]  out_ch_b;

   // Instance C: MODE=0, NUM_CH=3
   logic [1:0]  sel_c;
   logic [23:0] in_data_c;
   logic [2:0]  in_valid_c, in_last_c, in_ready_c;
   logic [7:0]  out_data_c;
   logic        out_valid_c, out_last_c, out_ready_c, sel_err_c;
   logic [1:0]  out_ch_c;

   stream_mux_nch #(.WORD_SIZE(8), .NUM_CH(4), .MODE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .sel(sel_a), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_last(in_last_a), .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
      .out_last(out_last_a), .out_ch(out_ch_a), .out_ready(out_ready_a), .sel_err(sel_err_a));

   stream_mux_nch #(.WORD_SIZE(8), .NUM_CH(4), .MODE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .sel(sel_b), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_last(in_last_b), .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
      .out_last(out_last_b), .out_ch(out_ch_b), .out_ready(out_ready_b), .sel_err(sel_err_b));

   stream_mux_nch #(.WORD_SIZE(8), .NUM_CH(3), .MODE(0)) u_c (
      .clk(clk), .rst_n(rst_n), .sel(sel_c), .in_data(in_data_c), .in_valid(in_valid_c),
      .in_last(in_last_c), .in_ready(in_ready_c), .out_data(out_data_c), .out_valid(out_valid_c),
      .out_last(out_last_c), .out_ch(out_ch_c), .out_ready(out_ready_c), .sel_err(sel_err_c));

   typedef struct {
      logic [1:0] sel;
      logic [3:0] vld;
      logic [3:0] lst;
      logic [7:0] d2;
      logic       ordy;
      logic [3:0] e_rdy;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_ol;
      logic [1:0] e_och;
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [7:0]  rx_data [$];
   logic        rx_last [$];
   logic [10:0] rec [$];
   int          rec_cyc [$];
   logic [7:0]  prev_data;
   bit          stall, acc_in, acc_out;
   int          sent, got, acc;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, got %0d expected 0", 1);
      $fatal(1);
   end

   initial begin
      vt[0] = '{2'd2, 4'b0100, 4'b0000, 8'hA1, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
      vt[1] = '{2'd1, 4'b0110, 4'b0000, 8'hA1, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0};
      vt[2] = '{2'd1, 4'b0110, 4'b0000, 8'hA2, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd2};
      vt[3] = '{2'd1, 4'b0110, 4'b0100, 8'hA3, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b0, 2'd2};
      vt[4] = '{2'd1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 8'hA3, 1'b1, 2'd2};
      vt[5] = '{2'd1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

      rst_n = 1'b0;
      sel_a = '0; in_data_a = '0; in_valid_a = '0; in_last_a = '0; out_ready_a = 1'b1;
      sel_b = 2'd3; in_data_b = '0; in_valid_b = '0; in_last_b = '0; out_ready_b = 1'b1;
      sel_c = 2'd3; in_data_c = '0; in_valid_c = '0; in_last_c = '0; out_ready_c = 1'b1;

      // Reset held for three edges with random traffic
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sel_a = 2'($urandom_range(3, 0)); in_valid_a = 4'($urandom); in_last_a = 4'($urandom);
         in_data_a = $urandom; in_valid_b = 4'($urandom); in_data_b = $urandom;
         in_valid_c = 3'b111; in_data_c = 24'($urandom); sel_c = 2'd3;
         out_ready_a = 1'($urandom_range(1, 0));
         #1;
         if (i > 0) begin
            chk("rst_a", 32'({out_valid_a, out_data_a, out_last_a, out_ch_a, in_ready_a, sel_err_a}), 32'd0);
            chk("rst_b", 32'({out_valid_b, out_data_b, out_last_b, out_ch_b, in_ready_b, sel_err_b}), 32'd0);
            chk("rst_c", 32'({out_valid_c, out_data_c, out_last_c, out_ch_c, in_ready_c, sel_err_c}), 32'd0);
         end
         @(posedge clk);
      end
      @(negedge clk);
      #1;
      chk("rst_a_last", 32'({out_valid_a, out_data_a, out_last_a, out_ch_a, in_ready_a, sel_err_a}), 32'd0);
      chk("rst_c_last", 32'({out_valid_c, out_data_c, out_last_c, out_ch_c, in_ready_c, sel_err_c}), 32'd0);
      rst_n = 1'b1;
      in_valid_a = '0; in_valid_b = '0; in_valid_c = '0; sel_c = 2'd0; out_ready_a = 1'b1;
      #1;
      chk("release_rdy_a", 32'(in_ready_a), 32'd0);
      chk("release_ov_a", 32'(out_valid_a), 32'd0);
      @(posedge clk);

      // Select-mode 3-beat packet on channel 2
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sel_a = vt[i].sel; in_valid_a = vt[i].vld; in_last_a = vt[i].lst;
         in_data_a = {8'hD3, vt[i].d2, 8'hD1, 8'hD0}; out_ready_a = vt[i].ordy;
         #1;
         chk($sformatf("vec%0d_rdy", i), 32'(in_ready_a), 32'(vt[i].e_rdy));
         chk($sformatf("vec%0d_ov", i), 32'(out_valid_a), 32'(vt[i].e_ov));
         if (vt[i].e_ov)
            chk($sformatf("vec%0d_out", i), 32'({out_data_a, out_last_a, out_ch_a}),
                32'({vt[i].e_od, vt[i].e_ol, vt[i].e_och}));
         @(posedge clk);
      end

      // Out-of-range select on a 3-channel instance
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sel_c = 2'd3; in_valid_c = 3'b111; in_last_c = 3'b000; in_data_c = 24'hC2C1C0;
         #1;
         chk($sformatf("selerr%0d", i), 32'(sel_err_c), 32'd1);
         chk($sformatf("selerr%0d_rdy", i), 32'(in_ready_c), 32'd0);
         chk($sformatf("selerr%0d_ov", i), 32'(out_valid_c), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      sel_c = 2'd0; in_valid_c = 3'b001;
      #1;
      chk("selok_err", 32'(sel_err_c), 32'd0);
      @(posedge clk);
      @(negedge clk);
      sel_c = 2'd3; in_last_c = 3'b001;
      #1;
      chk("sel_locked_err", 32'(sel_err_c), 32'd0);
      chk("sel_locked_rdy", 32'(in_ready_c), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid_c = '0; sel_c = 2'd0;
      #1;
      chk("sel_c_out", 32'({out_valid_c, out_data_c, out_last_c, out_ch_c}), 32'({1'b1, 8'hC0, 1'b1, 2'd0}));

      // Backpressure during a 5-beat packet on channel 0
      sent = 0; got = 0; stall = 0; prev_data = '0;
      for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
         @(negedge clk);
         sel_a = 2'd0;
         out_ready_a = (cyc > 150) ? 1'b1 : 1'($urandom_range(1, 0));
         in_valid_a = (sent < 5) ? 4'b0001 : 4'b0000;
         in_data_a = {24'h0, 8'(8'h50 + sent)};
         in_last_a = (sent == 4) ? 4'b0001 : 4'b0000;
         #1;
         if (stall) chk("bp_stable", 32'({out_valid_a, out_data_a}), 32'({1'b1, prev_data}));
         if (out_valid_a && !out_ready_a) chk("bp_rdy0", 32'(in_ready_a), 32'd0);
         acc_in  = in_valid_a[0] && in_ready_a[0];
         acc_out = out_valid_a && out_ready_a;
         stall   = out_valid_a && !out_ready_a;
         prev_data = out_data_a;
         if (acc_out) begin
            rx_data.push_back(out_data_a);
            rx_last.push_back(out_last_a);
         end
         @(posedge clk);
         if (acc_in) sent++;
         if (acc_out) got++;
      end
      chk("bp_count", 32'(got), 32'd5);
      for (int i = 0; i < rx_data.size() && i < 5; i++) begin
         chk($sformatf("bp_beat%0d", i), 32'({rx_data[i], rx_last[i]}),
             32'({8'(8'h50 + i), (i == 4) ? 1'b1 : 1'b0}));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_ready_a = 1'b1; in_valid_a = '0;
         #1;
         chk("bp_no_dup", 32'(out_valid_a), 32'd0);
         @(posedge clk);
      end

      // Round-robin with all channels offering single-beat packets
      @(negedge clk);
      sel_b = 2'd3; in_valid_b = 4'b1111; in_last_b = 4'b1111;
      in_data_b = 32'hC3C2C1C0; out_ready_b = 1'b1;
      for (int cyc = 0; cyc < 40 && rec.size() < 5; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         chk("rr_selerr", 32'(sel_err_b), 32'd0);
         if (out_valid_b) begin
            rec.push_back({out_ch_b, out_data_b, out_last_b});
            rec_cyc.push_back(cyc);
         end
         if (rec.size() == 5) in_valid_b = '0;
         else @(posedge clk);
      end
      chk("rr_count", 32'(rec.size()), 32'd5);
      for (int i = 0; i < rec.size() && i < 5; i++) begin
         chk($sformatf("rr_grant%0d", i), 32'(rec[i]),
             32'({2'(i % 4), 8'(8'hC0 + (i % 4)), 1'b1}));
         if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(rec_cyc[i] - rec_cyc[i-1]), 32'd2);
      end
      @(posedge clk);

      // Reset after beat 2 of a 4-beat packet on channel 2
      acc = 0;
      for (int cyc = 0; cyc < 30 && acc < 2; cyc++) begin
         @(negedge clk);
         in_valid_b = 4'b0100; in_last_b = 4'b0000;
         in_data_b = {8'h00, 8'(8'hE0 + acc), 16'h0000};
         #1;
         acc_in = in_valid_b[2] && in_ready_b[2];
         @(posedge clk);
         if (acc_in) acc++;
      end
      chk("mid_beats", 32'(acc), 32'd2);
      @(negedge clk);
      rst_n = 1'b0;
      in_data_b = {8'h00, 8'hE2, 16'h0000};
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; in_valid_b = '0;
      #1;
      chk("mid_rst_ov", 32'(out_valid_b), 32'd0);
      chk("mid_rst_rdy", 32'(in_ready_b), 32'd0);
      @(posedge clk);

      // Fresh 2-beat packet; the round-robin pointer should start at channel 0 again
      rec.delete();
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
         @(negedge clk);
         in_valid_b = (sent < 2) ? 4'b1111 : 4'b0000;
         in_data_b = {4{8'(8'hF0 + sent)}};
         in_last_b = (sent == 1) ? 4'b1111 : 4'b0000;
         out_ready_b = 1'b1;
         #1;
         acc_in  = |(in_valid_b & in_ready_b);
         acc_out = out_valid_b && out_ready_b;
         if (acc_out) rec.push_back({out_ch_b, out_data_b, out_last_b});
         @(posedge clk);
         if (acc_in) sent++;
         if (acc_out) got++;
      end
      chk("fresh_count", 32'(got), 32'd2);
      for (int i = 0; i < rec.size() && i < 2; i++) begin
         chk($sformatf("fresh_beat%0d", i), 32'(rec[i]),
             32'({2'd0, 8'(8'hF0 + i), (i == 1) ? 1'b1 : 1'b0}));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
